// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises the serial line, samples each bit at its centre
// and hands bytes to the host through a sticky ready flag plus FE/OE error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       UART_RXD,
    input  logic       UART_ACK_RX,
    output logic [7:0] UART_RxREG,
    output logic       UART_STA_RX,
    output logic       UART_ERR_FE,
    output logic       UART_ERR_OE,
    output logic       UART_BUSY_RX
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic             rxd_meta;
    logic             rxd_s;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             deliver;

    // The line is asynchronous to clk; it idles high, so the flops reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= UART_RXD;
            rxd_s    <= rxd_meta;
        end
    end

    // Once the start bit is confirmed at its centre, every later sample lands a
    // full bit period on, i.e. in the middle of each data bit and the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_idx      <= 3'd0;
            shreg        <= 8'h00;
            deliver      <= 1'b0;
            UART_RxREG   <= 8'h00;
            UART_STA_RX  <= 1'b0;
            UART_ERR_FE  <= 1'b0;
            UART_ERR_OE  <= 1'b0;
            UART_BUSY_RX <= 1'b0;
        end else begin
            deliver <= 1'b0;

            if (UART_ACK_RX) begin
                UART_STA_RX <= 1'b0;
                UART_ERR_FE <= 1'b0;
                UART_ERR_OE <= 1'b0;
            end

            // An ack arriving together with a new byte frees the register for it.
            if (deliver) begin
                if (!UART_STA_RX || UART_ACK_RX) begin
                    UART_RxREG  <= shreg;
                    UART_STA_RX <= 1'b1;
                end else begin
                    UART_ERR_OE <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state        <= START;
                        clk_cnt      <= '0;
                        UART_BUSY_RX <= 1'b1;
                    end
                end

                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        if (!rxd_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state        <= IDLE;
                            UART_BUSY_RX <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rxd_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Leaving mid-stop-bit keeps a directly following start edge visible.
                STOP: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        if (rxd_s) begin
                            state        <= IDLE;
                            deliver      <= 1'b1;
                            UART_BUSY_RX <= 1'b0;
                        end else begin
                            state       <= BREAK;
                            UART_ERR_FE <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rxd_s) begin
                        state        <= IDLE;
                        UART_BUSY_RX <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    UART_BUSY_RX <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames and compares the host-side
// flags and data against a frame-level model of the receiver.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       UART_RXD;
    logic       UART_ACK_RX;
    logic [7:0] UART_RxREG;
    logic       UART_STA_RX;
    logic       UART_ERR_FE;
    logic       UART_ERR_OE;
    logic       UART_BUSY_RX;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_reg;
    logic       m_sta;
    logic       m_fe;
    logic       m_oe;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .UART_RXD    (UART_RXD),
        .UART_ACK_RX (UART_ACK_RX),
        .UART_RxREG  (UART_RxREG),
        .UART_STA_RX (UART_STA_RX),
        .UART_ERR_FE (UART_ERR_FE),
        .UART_ERR_OE (UART_ERR_OE),
        .UART_BUSY_RX(UART_BUSY_RX)
    );

    always #5 clk = ~clk;

    // Host-visible behaviour per completed frame and per ack.
    task automatic model_reset();
        m_reg = 8'h00; m_sta = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    endtask

    task automatic model_good(input logic [7:0] b);
        if (!m_sta) begin
            m_reg = b;
            m_sta = 1'b1;
        end else begin
            m_oe = 1'b1;
        end
    endtask

    task automatic model_bad();
        m_fe = 1'b1;
    endtask

    task automatic model_ack();
        m_sta = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    endtask

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic drive_level(input logic v, input int n);
        UART_RXD = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        UART_ACK_RX = 1'b1;
        @(posedge clk);
        #1;
        UART_ACK_RX = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int ack_cycle);
        logic [9:0] fr;
        fr = {stop_val, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            UART_RXD    = fr[c / CPB];
            UART_ACK_RX = (c == ack_cycle);
            @(posedge clk);
            #1;
        end
        UART_ACK_RX = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; UART_RXD = 1'b1; UART_ACK_RX = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (UART_RxREG !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_rxreg: got %h, expected 00", UART_RxREG);
        end
        checks++;
        if ({UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000",
                     {UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX});
        end
        rst_n = 1'b1;
        drive_level(1'b1, 5);
        checks++;
        if (UART_BUSY_RX !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_busy: got %b, expected 0", UART_BUSY_RX);
        end
    endtask

    task automatic test_single_byte();
        int   lat;
        logic found;
        lat = 0; found = 1'b0;
        fork
            send_frame(8'hAA, 1'b1, -1);
            begin
                for (int i = 1; i <= 300 && !found; i++) begin
                    @(posedge clk);
                    #1;
                    if (UART_STA_RX === 1'b1) begin
                        found = 1'b1;
                        lat   = i - 1;
                    end
                end
            end
        join
        model_good(8'hAA);
        checks++;
        if (!found || lat < 154 || lat > 156) begin
            failures++;
            $display("[TB] FAIL latency: got %0d cycles (seen=%b), expected 155 +/-1", lat, found);
        end
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
            failures++;
            $display("[TB] FAIL single_byte: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
        end
        pulse_ack();
        model_ack();
        checks++;
        if ({UART_RxREG, UART_STA_RX} !== {m_reg, m_sta}) begin
            failures++;
            $display("[TB] FAIL single_ack: got %h, expected %h", {UART_RxREG, UART_STA_RX}, {m_reg, m_sta});
        end
    endtask

    task automatic test_stream();
        logic [7:0] bytes [8];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'hAA;
        for (int i = 4; i < 8; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            send_frame(bytes[i], 1'b1, -1);
            drive_level(1'b1, 2);
            model_good(bytes[i]);
            checks++;
            if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
                failures++;
                $display("[TB] FAIL stream_byte%0d: got %h, expected %h", i,
                         {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
            end
            pulse_ack();
            model_ack();
        end
        checks++;
        if (UART_STA_RX !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stream_final_sta: got %b, expected 0", UART_STA_RX);
        end
    endtask

    task automatic test_glitch();
        drive_level(1'b0, 4);
        checks++;
        if (UART_BUSY_RX !== 1'b1) begin
            failures++;
            $display("[TB] FAIL glitch_busy_rise: got %b, expected 1", UART_BUSY_RX);
        end
        drive_level(1'b1, 20);
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_BUSY_RX} !== {m_reg, 3'b000}) begin
            failures++;
            $display("[TB] FAIL glitch_reject: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_BUSY_RX}, {m_reg, 3'b000});
        end
    endtask

    task automatic test_framing();
        logic [7:0] prev;
        logic [7:0] next;
        prev = 8'($urandom);
        next = 8'($urandom);
        send_frame(prev, 1'b1, -1);
        model_good(prev);
        send_frame(8'h3C, 1'b0, -1);
        model_bad();
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX} !== {m_reg, m_sta, m_fe, m_oe, 1'b1}) begin
            failures++;
            $display("[TB] FAIL framing_error: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX},
                     {m_reg, m_sta, m_fe, m_oe, 1'b1});
        end
        pulse_ack();
        model_ack();
        drive_level(1'b0, 32);
        checks++;
        if ({UART_ERR_FE, UART_BUSY_RX} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL framing_single_fe: got %b, expected 01", {UART_ERR_FE, UART_BUSY_RX});
        end
        drive_level(1'b1, 8);
        checks++;
        if (UART_BUSY_RX !== 1'b0) begin
            failures++;
            $display("[TB] FAIL break_exit: got %b, expected 0", UART_BUSY_RX);
        end
        send_frame(next, 1'b1, -1);
        drive_level(1'b1, 2);
        model_good(next);
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
            failures++;
            $display("[TB] FAIL framing_recover: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
        end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, -1);
        drive_level(1'b1, 2);
        model_good(8'h11);
        send_frame(8'h22, 1'b1, -1);
        drive_level(1'b1, 2);
        model_good(8'h22);
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
            failures++;
            $display("[TB] FAIL overrun: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
        end
        pulse_ack();
        model_ack();
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_OE} !== {m_reg, m_sta, m_oe}) begin
            failures++;
            $display("[TB] FAIL overrun_ack: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_OE}, {m_reg, m_sta, m_oe});
        end
    endtask

    // The ack lands on the same edge that the second byte is handed over.
    task automatic test_ack_collision();
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = 8'($urandom);
        b2 = ~b1;
        send_frame(b1, 1'b1, -1);
        model_good(b1);
        send_frame(b2, 1'b1, 155);
        model_ack();
        model_good(b2);
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
            failures++;
            $display("[TB] FAIL ack_collision: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
        end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        send_frame(b1, 1'b1, -1);
        model_good(b1);
        checks++;
        if ({UART_RxREG, UART_STA_RX} !== {m_reg, m_sta}) begin
            failures++;
            $display("[TB] FAIL b2b_first: got %h, expected %h", {UART_RxREG, UART_STA_RX}, {m_reg, m_sta});
        end
        send_frame(b2, 1'b1, 20);
        model_ack();
        model_good(b2);
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
            failures++;
            $display("[TB] FAIL b2b_second: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
        end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pre;
        logic [7:0] part;
        pre  = 8'($urandom);
        part = 8'($urandom);
        send_frame(pre, 1'b1, -1);
        model_good(pre);
        drive_level(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_level(part[i], CPB);
        drive_level(part[4], 8);
        checks++;
        if (UART_BUSY_RX !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midframe_busy: got %b, expected 1", UART_BUSY_RX);
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX} !== {m_reg, m_sta, m_fe, m_oe, 1'b0}) begin
            failures++;
            $display("[TB] FAIL midframe_reset: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX},
                     {m_reg, m_sta, m_fe, m_oe, 1'b0});
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_level(1'b1, 10);
        send_frame(8'hC3, 1'b1, -1);
        drive_level(1'b1, 2);
        model_good(8'hC3);
        checks++;
        if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX} !== {m_reg, m_sta, m_fe, m_oe, 1'b0}) begin
            failures++;
            $display("[TB] FAIL after_reset_frame: got %h, expected %h",
                     {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX},
                     {m_reg, m_sta, m_fe, m_oe, 1'b0});
        end
        pulse_ack();
        model_ack();
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int it = 0; it < 12; it++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 9) < 2) begin
                send_frame(b, 1'b0, -1);
                drive_level(1'b1, CPB);
                model_bad();
            end else begin
                send_frame(b, 1'b1, -1);
                model_good(b);
            end
            drive_level(1'b1, $urandom_range(1, 5));
            checks++;
            if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX} !== {m_reg, m_sta, m_fe, m_oe, 1'b0}) begin
                failures++;
                $display("[TB] FAIL random_frame%0d: got %h, expected %h", it,
                         {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE, UART_BUSY_RX},
                         {m_reg, m_sta, m_fe, m_oe, 1'b0});
            end
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                model_ack();
                checks++;
                if ({UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE} !== {m_reg, m_sta, m_fe, m_oe}) begin
                    failures++;
                    $display("[TB] FAIL random_ack%0d: got %h, expected %h", it,
                             {UART_RxREG, UART_STA_RX, UART_ERR_FE, UART_ERR_OE}, {m_reg, m_sta, m_fe, m_oe});
                end
            end
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_byte();
        test_stream();
        test_glitch();
        test_framing();
        test_overrun();
        test_ack_collision();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
